// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter.
// Each granted port keeps the grant for up to max(weight,1) beats before rotation,
// so masters get a share proportional to their weight without starving others.
//
// Ports:
//   clk            clock
//   rst            asynchronous active-high reset
//   request        per-port level request
//   acknowledge    per-port beat acknowledge (only the granted bit is observed)
//   weight         packed per-port weights, port i at [i*WEIGHT_W +: WEIGHT_W]; 0 acts as 1
//   grant          one-hot grant (registered)
//   grant_valid    grant active (registered)
//   grant_encoded  index of the granted port (registered)
//   credit_count   beats remaining in the current grant, 0 when idle (registered)
module wrr_arbiter #(
    parameter int unsigned PORTS                 = 4,
    parameter int unsigned WEIGHT_W              = 4,
    parameter int unsigned ARB_LSB_HIGH_PRIORITY = 1,
    parameter int unsigned ARB_BLOCK_ACK         = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PORTS-1:0]            request,
    input  logic [PORTS-1:0]            acknowledge,
    input  logic [PORTS*WEIGHT_W-1:0]   weight,
    output logic [PORTS-1:0]            grant,
    output logic                        grant_valid,
    output logic [$clog2(PORTS)-1:0]    grant_encoded,
    output logic [WEIGHT_W-1:0]         credit_count
);

    localparam int unsigned ENC_W = $clog2(PORTS);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [PORTS-1:0]      mask_q;
    logic [PORTS-1:0]      mask_d;
    logic [PORTS-1:0]      grant_d;
    logic                  grant_valid_d;
    logic [ENC_W-1:0]      grant_encoded_d;
    logic [WEIGHT_W-1:0]   credit_d;

    logic [PORTS-1:0]      masked;
    logic [PORTS-1:0]      sel;
    logic [ENC_W-1:0]      win_idx;
    logic [WEIGHT_W-1:0]   win_w;
    logic [PORTS-1:0]      win_mask;
    logic                  any_req;
    logic                  req_g;
    logic                  ack_g;
    logic                  beat;
    logic                  release_grant;

    // Winner selection: rotate via mask, fall back to plain priority when the masked set is empty.
    always_comb begin : arb_select
        masked   = request & mask_q;
        sel      = (|masked) ? masked : request;
        any_req  = |request;
        win_idx  = '0;
        win_w    = '0;
        win_mask = '0;
        if (ARB_LSB_HIGH_PRIORITY != 0) begin
            // Descending scan so the lowest set bit is the last one written.
            for (int i = int'(PORTS) - 1; i >= 0; i--) begin
                if (sel[i]) begin
                    win_idx = ENC_W'(i);
                    win_w   = weight[i*int'(WEIGHT_W) +: WEIGHT_W];
                end
            end
        end else begin
            for (int i = 0; i < int'(PORTS); i++) begin
                if (sel[i]) begin
                    win_idx = ENC_W'(i);
                    win_w   = weight[i*int'(WEIGHT_W) +: WEIGHT_W];
                end
            end
        end
        for (int j = 0; j < int'(PORTS); j++) begin
            if (ARB_LSB_HIGH_PRIORITY != 0) begin
                win_mask[j] = (j > int'(win_idx));
            end else begin
                win_mask[j] = (j < int'(win_idx));
            end
        end
    end

    // Beat / release detection on the currently granted port (grant is one-hot).
    always_comb begin : beat_detect
        req_g         = |(request & grant);
        ack_g         = |(acknowledge & grant);
        beat          = (ARB_BLOCK_ACK != 0) ? ack_g : req_g;
        release_grant = (beat && (credit_count == WEIGHT_W'(1))) || (!req_g && !beat);
    end

    // Next-state and next-output logic.
    always_comb begin : next_state
        state_d         = state_q;
        mask_d          = mask_q;
        grant_d         = grant;
        grant_valid_d   = grant_valid;
        grant_encoded_d = grant_encoded;
        credit_d        = credit_count;

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d         = GRANT;
                    mask_d          = win_mask;
                    grant_d         = PORTS'(1) << win_idx;
                    grant_valid_d   = 1'b1;
                    grant_encoded_d = win_idx;
                    credit_d        = (win_w == '0) ? WEIGHT_W'(1) : win_w;
                end
            end
            GRANT: begin
                if (release_grant) begin
                    if (any_req) begin
                        // Back-to-back handover, no idle bubble.
                        mask_d          = win_mask;
                        grant_d         = PORTS'(1) << win_idx;
                        grant_valid_d   = 1'b1;
                        grant_encoded_d = win_idx;
                        credit_d        = (win_w == '0) ? WEIGHT_W'(1) : win_w;
                    end else begin
                        state_d         = IDLE;
                        grant_d         = '0;
                        grant_valid_d   = 1'b0;
                        grant_encoded_d = '0;
                        credit_d        = '0;
                    end
                end else if (beat) begin
                    credit_d = credit_count - WEIGHT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin : regs
        if (rst) begin
            state_q       <= IDLE;
            mask_q        <= '0;
            grant         <= '0;
            grant_valid   <= 1'b0;
            grant_encoded <= '0;
            credit_count  <= '0;
        end else begin
            state_q       <= state_d;
            mask_q        <= mask_d;
            grant         <= grant_d;
            grant_valid   <= grant_valid_d;
            grant_encoded <= grant_encoded_d;
            credit_count  <= credit_d;
        end
    end

endmodule

// File: tb/tb_wrr_arbiter.sv
// Testbench for wrr_arbiter: two instances (block-ack/LSB-high and cycle-mode/MSB-high)
// share stimulus; each is compared every cycle against a search-order reference model.
module tb_wrr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  request;
    logic [3:0]  acknowledge;
    logic [15:0] weight;

    logic [3:0]  ga, gb;
    logic        gva, gvb;
    logic [1:0]  gea, geb;
    logic [3:0]  cca, ccb;

    int errors;
    int checks;

    // Reference model state per instance: 0 = dut_a, 1 = dut_b.
    int m_act [2];
    int m_g   [2];
    int m_cr  [2];
    int m_last[2];

    wrr_arbiter #(.PORTS(4), .WEIGHT_W(4), .ARB_LSB_HIGH_PRIORITY(1), .ARB_BLOCK_ACK(1)) dut_a (
        .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge), .weight(weight),
        .grant(ga), .grant_valid(gva), .grant_encoded(gea), .credit_count(cca)
    );

    wrr_arbiter #(.PORTS(4), .WEIGHT_W(4), .ARB_LSB_HIGH_PRIORITY(0), .ARB_BLOCK_ACK(0)) dut_b (
        .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge), .weight(weight),
        .grant(gb), .grant_valid(gvb), .grant_encoded(geb), .credit_count(ccb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int wt(int p);
        int w;
        w = int'(weight[p*4 +: 4]);
        return (w == 0) ? 1 : w;
    endfunction

    // Walk the ports in search order starting just past the last granted port.
    function automatic int pick(int d);
        int idx;
        for (int k = 1; k <= 4; k++) begin
            idx = (d == 0) ? (m_last[d] + k) % 4 : (m_last[d] - k + 8) % 4;
            if (request[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_act[d]  = 0;
            m_g[d]    = 0;
            m_cr[d]   = 0;
            m_last[d] = (d == 0) ? 3 : 0;
        end
    endfunction

    function automatic void model_load(int d, int w);
        m_act[d]  = 1;
        m_g[d]    = w;
        m_cr[d]   = wt(w);
        m_last[d] = w;
    endfunction

    function automatic void model_step(int d);
        int  w;
        bit  rq;
        bit  bt;
        if (m_act[d] == 0) begin
            w = pick(d);
            if (w >= 0) model_load(d, w);
        end else begin
            rq = request[m_g[d]];
            bt = (d == 0) ? acknowledge[m_g[d]] : rq;
            if ((bt && m_cr[d] == 1) || (!rq && !bt)) begin
                w = pick(d);
                if (w >= 0) model_load(d, w);
                else begin
                    m_act[d] = 0;
                    m_cr[d]  = 0;
                end
            end else if (bt) begin
                m_cr[d] = m_cr[d] - 1;
            end
        end
    endfunction

    task automatic check_all();
        logic [3:0] eg;
        for (int d = 0; d < 2; d++) begin
            eg = (m_act[d] != 0) ? 4'(1 << m_g[d]) : 4'd0;
            if (d == 0) begin
                check("a_grant",   32'(ga),  32'(eg));
                check("a_valid",   32'(gva), 32'(m_act[d]));
                check("a_encoded", 32'(gea), (m_act[d] != 0) ? 32'(m_g[d]) : 32'd0);
                check("a_credit",  32'(cca), (m_act[d] != 0) ? 32'(m_cr[d]) : 32'd0);
            end else begin
                check("b_grant",   32'(gb),  32'(eg));
                check("b_valid",   32'(gvb), 32'(m_act[d]));
                check("b_encoded", 32'(geb), (m_act[d] != 0) ? 32'(m_g[d]) : 32'd0);
                check("b_credit",  32'(ccb), (m_act[d] != 0) ? 32'(m_cr[d]) : 32'd0);
            end
        end
    endtask

    // One clock: model sees the same pre-edge inputs as the DUTs, outputs sampled 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        model_reset();
        check_all();
        rst = 1'b0;
    endtask

    int share_seq [10] = '{0, 1, 1, 2, 2, 2, 3, 3, 3, 3};
    int cyc_seq   [17] = '{3, 3, 2, 2, 1, 1, 0, 0, 3, 3, 2, 2, 1, 1, 0, 0, 3};
    int gate_cr   [5]  = '{3, 2, 2, 1, 1};

    initial begin
        errors      = 0;
        checks      = 0;
        rst         = 1'b1;
        request     = '0;
        acknowledge = '0;
        weight      = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;

        // Idle with no requests.
        repeat (2) cycle();

        // Async reset mid-grant: port 2 with credit 3.
        weight  = 16'h0300;
        request = 4'b0100;
        cycle();
        check("rst_pre_grant",  32'(ga),  32'h4);
        check("rst_pre_credit", 32'(cca), 32'd3);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_async_grant",  32'(ga),  32'd0);
        check("rst_async_credit", 32'(cca), 32'd0);
        check("rst_async_valid",  32'(gvb), 32'd0);
        check_all();
        rst = 1'b0;
        cycle();
        request = 4'b0000;
        cycle();
        check("idle_after_release", 32'(gva), 32'd0);
        repeat (2) cycle();

        // Weighted share on dut_a: weights {1,2,3,4}, all requesting, ack always.
        do_reset();
        weight      = {4'd4, 4'd3, 4'd2, 4'd1};
        request     = 4'hF;
        acknowledge = 4'hF;
        for (int k = 0; k < 20; k++) begin
            cycle();
            check("share_seq",   32'(gea), 32'(share_seq[k % 10]));
            check("share_valid", 32'(gva), 32'd1);
        end

        // Early release on dut_a: port 1 weight 5 drops after 2 acks, port 3 takes over.
        do_reset();
        weight      = {4'd2, 4'd0, 4'd5, 4'd0};
        request     = 4'b1010;
        acknowledge = 4'b0000;
        cycle();
        check("early_first", 32'(gea), 32'd1);
        check("early_cr5",   32'(cca), 32'd5);
        acknowledge = 4'b0010;
        repeat (2) cycle();
        check("early_cr3", 32'(cca), 32'd3);
        acknowledge = 4'b0000;
        request     = 4'b1000;
        cycle();
        check("early_to3",   32'(gea), 32'd3);
        check("early_cr_w3", 32'(cca), 32'd2);
        request = 4'b0011;
        cycle();
        check("early_mask_p0", 32'(gea), 32'd0);

        // Sole requester with zero weight: one-beat grants back-to-back.
        do_reset();
        weight      = 16'h0000;
        request     = 4'b0001;
        acknowledge = 4'b0001;
        for (int k = 0; k < 6; k++) begin
            cycle();
            check("sole_enc",    32'(gea), 32'd0);
            check("sole_credit", 32'(cca), 32'd1);
            check("sole_valid",  32'(gva), 32'd1);
        end

        // Ack gating: port 2 weight 3, ack[2] every other cycle, ack[0] toggling.
        do_reset();
        weight      = 16'h0300;
        request     = 4'b0100;
        acknowledge = 4'b0000;
        cycle();
        check("gate_grant", 32'(gea), 32'd2);
        check("gate_cr0",   32'(cca), 32'd3);
        request = 4'b0101;
        for (int k = 0; k < 6; k++) begin
            acknowledge = {1'b0, 1'(k % 2), 1'b0, 1'((k + 1) % 2)};
            cycle();
            if (k < 5) begin
                check("gate_hold",   32'(gea), 32'd2);
                check("gate_credit", 32'(cca), 32'(gate_cr[k]));
            end else begin
                check("gate_next", 32'(gea), 32'd0);
            end
        end

        // Cycle mode, MSB-high on dut_b: all weights 2; weight[3] changed mid-grant.
        do_reset();
        weight      = 16'h2222;
        request     = 4'hF;
        acknowledge = 4'h0;
        for (int k = 0; k < 17; k++) begin
            cycle();
            check("cyc_seq", 32'(geb), 32'(cyc_seq[k]));
            if (k == 8) weight = 16'h5222;
            if (k == 9)  check("cyc_old_weight", 32'(ccb), 32'd1);
            if (k == 16) check("cyc_new_weight", 32'(ccb), 32'd5);
        end

        // Randomized traffic checked against the model.
        do_reset();
        weight = 16'($urandom);
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 3) == 0) request = 4'($urandom);
            acknowledge = 4'($urandom);
            if ($urandom_range(0, 15) == 0) weight = 16'($urandom);
            cycle();
            if ($urandom_range(0, 199) == 0) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wrr_arbiter.md
Name: wrr_arbiter

Overview:
Parametrised weighted round-robin arbiter. It is the successor to the team's plain round-robin/priority arbiter. Each port holds the grant for up to a programmable number of acknowledged beats before rotation, so high-bandwidth masters get a proportional share without starving others. It sits in front of shared interconnect ports: DMA read/write muxes and memory controller front-ends.

Parameters:
PORTS, 4, number of requesters (>=2)
WEIGHT_W, 4, width of each per-port weight field and of the credit counter
ARB_LSB_HIGH_PRIORITY, 1, 1: search order upward from the last grant (port 0 highest after wrap); 0: search order downward (port PORTS-1 highest)
ARB_BLOCK_ACK, 1, 1: credit consumed per acknowledge beat; 0: credit consumed per granted cycle while the request is held

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
request  in  PORTS  per-port request, level
acknowledge  in  PORTS  per-port beat acknowledge; only the bit of the granted port is observed
weight  in  PORTS*WEIGHT_W  packed weights, port i at [i*WEIGHT_W +: WEIGHT_W]; value 0 is treated as 1
grant  out  PORTS  one-hot grant, registered
grant_valid  out  1  grant is active, registered
grant_encoded  out  clog2(PORTS)  index of the granted port, registered
credit_count  out  WEIGHT_W  beats remaining in the current grant, registered; 0 when idle

Behaviour:
- Reset (asynchronous, any time, including mid-grant): grant=0, grant_valid=0, grant_encoded=0, credit_count=0, rotation mask=0, FSM=IDLE. Reset takes effect immediately with no wait for clk.
- Two-state FSM, IDLE and GRANT. All outputs change only on clk rising edge.
- IDLE: if any request is set, select a winner; next edge FSM=GRANT, grant/grant_valid/grant_encoded reflect the winner, and credit_count=max(weight[winner],1). Latency from request to grant is 1 cycle. With no request, the FSM stays IDLE and outputs stay 0.
- Winner selection: priority-encode request & mask. If that result is empty, priority-encode the full request vector.
- Mask after granting port g: with ARB_LSB_HIGH_PRIORITY=1, bits strictly above g; with ARB_LSB_HIGH_PRIORITY=0, bits strictly below g. Mask after reset is 0, so the first selection is plain priority.
- The mask updates only when a new grant is issued.
- GRANT, beat condition: with ARB_BLOCK_ACK=1, a beat is acknowledge[g]=1; with ARB_BLOCK_ACK=0, a beat is request[g]=1. Each beat decrements credit_count by 1.
- GRANT, release condition: a beat occurs while credit_count==1, OR request[g]=0 with no beat in the same cycle.
- GRANT, on release in cycle N: arbitration runs in cycle N using the current request and the updated mask.
  - If any request is set, at edge N+1 the new grant is loaded back-to-back. grant_valid stays 1 with no idle bubble.
  - If no request is set, at edge N+1 FSM=IDLE and all outputs return to 0.
- Sole requester: port g is re-granted immediately through the fallback path, with fresh credit=weight[g].
- GRANT without release: grant outputs hold. credit_count decrements only on a beat.
- Simultaneous events: if the last-credit beat and the request drop happen in the same cycle, there is exactly one release. Acknowledge bits of non-granted ports are ignored. Requests from other ports never pre-empt a grant.
- Weight is sampled only when a grant is issued. Weight changes during a grant take effect at that port's next grant.
- Width: credit_count never underflows and is never 0 while grant_valid=1. The maximum burst is 2^WEIGHT_W-1 beats.
- Invariants: grant is one-hot or zero, grant_valid == |grant, and grant_encoded matches grant.

Test Plan:
- Reset/idle: rst pulsed asynchronously mid-cycle while port 2 is granted with credit 3 -> all outputs go to 0 before the next edge. After release with no requests, outputs stay 0.
- Weighted share: PORTS=4, weights {1,2,3,4}, all requests held, acknowledge always 1 -> grant sequence per 10 beats is 0,1,1,2,2,2,3,3,3,3 and repeats. grant_valid stays 1 continuously.
- Early release: port 1 granted with weight 5; after 2 acks, request[1] drops with no ack -> port 3 (the only other requester) is granted on the next edge with credit=weight[3]. The mask then favours port 0 over port 1.
- Sole requester / zero weight: only port 0 requests with weight=0 -> grant held for exactly 1 beat, then re-granted back-to-back each beat, with credit_count=1 every cycle.
- Ack gating: ARB_BLOCK_ACK=1, port 2 granted with weight 3, ack high only every other cycle, and acknowledge[0] toggling -> grant held for 6 cycles. credit_count goes 3,3,2,2,1,1. The acknowledges on port 0 have no effect.
- Cycle mode and direction: ARB_BLOCK_ACK=0, ARB_LSB_HIGH_PRIORITY=0, all weights 2, all ports requesting -> grants go 3,3,2,2,1,1,0,0,3,3. A weight change applied mid-grant is seen only at the next grant.
